// File: rtl/data_mem_wait.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_wait
//  Description : Single-port word memory with byte-lane writes and a fixed,
//                parameterised number of wait states per access. Misaligned
//                accesses complete with err and have no memory effect.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_wait #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                busy,
  output logic                ack,
  output logic                err,
  output logic [DATA_W-1:0]   rdata
);

  localparam int c_BYTES  = DATA_W / 8;
  localparam int c_LANE_W = (c_BYTES > 1) ? $clog2(c_BYTES) : 0;
  localparam int c_IDX_W  = ADDR_W - c_LANE_W;
  localparam int c_DEPTH  = 2 ** c_IDX_W;
  localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [3:0]          r_waitCnt;
  logic [3:0]          w_nextCnt;
  logic                w_accept;

  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [c_BYTES-1:0]  r_be;
  logic                r_err;
  logic [DATA_W-1:0]   r_rdata;

  // Operands of the access being performed this edge; with zero wait states
  // the access happens on the same edge that samples the request.
  logic                w_opWe;
  logic [ADDR_W-1:0]   w_opAddr;
  logic [DATA_W-1:0]   w_opWdata;
  logic [c_BYTES-1:0]  w_opBe;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_misaligned;
  logic                w_enterResp;
  logic                w_memWr;
  logic                w_memRd;

  logic [DATA_W-1:0]   mem [c_DEPTH];

  // Next-state and wait-counter logic
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_waitCnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          if (WAIT_STATES > 0) begin
            w_nextState = S_WAIT;
            w_nextCnt   = c_WAIT_LOAD;
          end else begin
            w_nextState = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (r_waitCnt == 4'd0) begin
          w_nextState = S_RESP;
        end else begin
          w_nextCnt = r_waitCnt - 4'd1;
        end
      end
      S_RESP:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  assign w_opWe    = (r_state == S_IDLE) ? we    : r_we;
  assign w_opAddr  = (r_state == S_IDLE) ? addr  : r_addr;
  assign w_opWdata = (r_state == S_IDLE) ? wdata : r_wdata;
  assign w_opBe    = (r_state == S_IDLE) ? be    : r_be;
  assign w_idx     = w_opAddr[ADDR_W-1:c_LANE_W];

  generate
    if (c_LANE_W > 0) begin : g_align
      assign w_misaligned = |w_opAddr[c_LANE_W-1:0];
    end else begin : g_noAlign
      assign w_misaligned = 1'b0;
    end
  endgenerate

  // rst gating keeps a zero-wait-state access from firing while held in reset
  assign w_enterResp = (w_nextState == S_RESP) && (r_state != S_RESP);
  assign w_memWr     = w_enterResp && w_opWe && !w_misaligned && rst;
  assign w_memRd     = w_enterResp && !w_opWe && !w_misaligned;

  // State, counter and request-latch registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_waitCnt <= 4'd0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_be      <= '0;
    end else begin
      r_state   <= w_nextState;
      r_waitCnt <= w_nextCnt;
      if (w_accept) begin
        r_we    <= we;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_be    <= be;
      end
    end
  end

  // Response registers: error flag and read data captured on entry to RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_enterResp) begin
        r_err <= w_misaligned;
      end
      if (w_memRd) begin
        r_rdata <= mem[w_idx];
      end
    end
  end

  // Byte-lane writes into the storage array; contents are never reset
  always_ff @(posedge clk) begin
    if (w_memWr) begin
      for (int i = 0; i < c_BYTES; i++) begin
        if (w_opBe[i]) begin
          mem[w_idx][8*i +: 8] <= w_opWdata[8*i +: 8];
        end
      end
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign ack   = (r_state == S_RESP);
  assign err   = ack & r_err;
  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: doc/data_mem_wait.md
DATA_MEM_WAIT -- requirements
Module: data_mem_wait

Interface
REQ-001 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 9, byte-address width; depth SHALL be 2^ADDR_W/(DATA_W/8) words.
REQ-003 Parameter WAIT_STATES, default 2, added access cycles; legal range 0..15.
REQ-004 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  reset; asynchronous, active-low.
REQ-006 Port req  input  1  access request; sampled only in IDLE.
REQ-007 Port we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 Port addr  input  ADDR_W  byte address; sampled with req.
REQ-009 Port wdata  input  DATA_W  write data; sampled with req.
REQ-010 Port be  input  DATA_W/8  byte-lane write enables; bit i covers wdata[8i+7:8i].
REQ-011 Port busy  output  1  high while an accepted request is in progress (WAIT or RESP).
REQ-012 Port ack  output  1  one-cycle completion pulse.
REQ-013 Port err  output  1  valid with ack; 1 = misaligned access, no memory effect.
REQ-014 Port rdata  output  DATA_W  read data; valid with ack for an aligned read.

Function
REQ-015 FSM SHALL have states IDLE, WAIT, RESP.
REQ-016 IDLE with req=1: latch we/addr/wdata/be; go to WAIT if WAIT_STATES>0, else RESP.
REQ-017 IDLE with req=0: remain in IDLE; no memory activity.
REQ-018 WAIT: down-counter loaded with WAIT_STATES-1 on accept; go to RESP when it reaches 0.
REQ-019 Transition into RESP SHALL perform the access: write the enabled byte lanes of latched wdata, or register the addressed word into rdata.
REQ-020 RESP: ack=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-021 Latency from the req-sampling edge to ack high SHALL be WAIT_STATES+1 cycles.
REQ-022 req during WAIT or RESP SHALL be ignored (not queued); max throughput is one access per WAIT_STATES+2 cycles.
REQ-023 Misaligned: addr[log2(DATA_W/8)-1:0] != 0 SHALL give err=1 with ack, no write, rdata unchanged; latency identical to an aligned access.
REQ-024 Word index = addr[ADDR_W-1:log2(DATA_W/8)]; the top word SHALL be fully accessible, with no wrap-around or aliasing.
REQ-025 Write with be=0 SHALL leave memory unchanged and still ack with err=0.
REQ-026 A read SHALL return the full word irrespective of be.
REQ-027 A read of a word not written since power-up SHALL return X in simulation; memory contents are not reset.
REQ-028 rdata SHALL hold its last value outside RESP and after a write.

Reset
REQ-029 When rst is low: state=IDLE, counter=0, busy=0, ack=0, err=0, rdata=0, asynchronously.
REQ-030 rst low in WAIT aborts the access with no write; rst low in RESP leaves the already-performed write intact and suppresses ack.
REQ-031 First req SHALL be sampled on the first rising edge after rst goes high.

Verification (DATA_W=32, ADDR_W=9, WAIT_STATES=2)
REQ-032 Write addr=0x010 wdata=0xDEADBEEF be=4'hF, then read 0x010 -> each ack 3 cycles after req; rdata=0xDEADBEEF, err=0.
REQ-033 Write 0x010 wdata=0x00000011 be=4'b0001, then read -> rdata=0xDEADBE11.
REQ-034 Read addr=0x013 -> ack with err=1 after 3 cycles; rdata unchanged; busy high for 3 cycles.
REQ-035 Write 0x1FC=0x12345678, read 0x1FC and 0x000 -> 0x1FC returns 0x12345678; word 0 unaffected.
REQ-036 req held high continuously for 12 cycles -> exactly 3 accesses accepted, ack every 4th cycle.
REQ-037 Write 0x020=0xCAFEF00D, rst low for 1 cycle during WAIT, then read 0x020 -> prior contents returned, no ack for aborted access.
